// File: rtl/counter_mod_updown_shift.sv
// counter_mod_updown_shift: modulo up/down counter with parallel load, shift/rotate,
// carry/borrow pulses and a sticky error flag.
// Build option: define COUNTER_MOD_SATURATE_EN to make increment/decrement
// saturate at the range limits instead of wrapping.
module counter_mod_updown_shift #(
  parameter int unsigned      WIDTH     = 8,
  parameter longint unsigned  MODULUS   = 256,
  parameter int unsigned      STEP      = 1,
  parameter int unsigned      RESET_VAL = 0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic             L,
  input  logic             INC,
  input  logic             DEC,
  input  logic             SHL,
  input  logic             SHR,
  input  logic             ROT,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             BO,
  output logic             ERR
);

  // Arithmetic is done one bit wider so Q+STEP and Q+MODULUS never overflow.
  localparam int unsigned      W1     = WIDTH + 1;
  localparam logic [W1-1:0]    MOD_W  = W1'(MODULUS);
  localparam logic [W1-1:0]    STEP_W = W1'(STEP);
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic             bo_q, bo_d;
  logic             err_q, err_d;

  logic [W1-1:0]    q_ext;
  logic [W1-1:0]    inc_sum;
  logic [W1-1:0]    dec_diff;
  logic [W1-1:0]    dec_wrap;
  logic             inc_over;
  logic             dec_under;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic             shl_bad;
  logic             shr_bad;
  logic             load_bad;

  // Candidate results for every operation, selected below by priority.
  always_comb begin
    q_ext     = {1'b0, q_q};
    inc_sum   = q_ext + STEP_W;
    dec_diff  = q_ext - STEP_W;
    dec_wrap  = q_ext + MOD_W - STEP_W;
    inc_over  = (inc_sum >= MOD_W);
    dec_under = (q_ext < STEP_W);
`ifdef COUNTER_MOD_SATURATE_EN
    inc_val   = inc_over  ? MAX_Q : WIDTH'(inc_sum);
    dec_val   = dec_under ? '0    : WIDTH'(dec_diff);
`else
    inc_val   = inc_over  ? WIDTH'(inc_sum - MOD_W) : WIDTH'(inc_sum);
    dec_val   = dec_under ? WIDTH'(dec_wrap)        : WIDTH'(dec_diff);
`endif
    shl_val   = {q_q[WIDTH-2:0], (ROT ? q_q[WIDTH-1] : SIL)};
    shr_val   = {(ROT ? q_q[0] : SIR), q_q[WIDTH-1:1]};
    shl_bad   = ({1'b0, shl_val} >= MOD_W);
    shr_bad   = ({1'b0, shr_val} >= MOD_W);
    load_bad  = ({1'b0, D} >= MOD_W);
  end

  // Next-state selection: L > INC > DEC > SHL > SHR > hold, gated by CE.
  always_comb begin
    q_d   = q_q;
    co_d  = 1'b0;
    bo_d  = 1'b0;
    err_d = err_q;
    if (CE) begin
      if (L) begin
        if (load_bad) begin
          q_d   = MAX_Q;
          err_d = 1'b1;
        end else begin
          q_d = D;
        end
      end else if (INC) begin
        q_d  = inc_val;
        co_d = inc_over;
        if (DEC) begin
          err_d = 1'b1;
        end
      end else if (DEC) begin
        q_d  = dec_val;
        bo_d = dec_under;
      end else if (SHL) begin
        if (shl_bad) begin
          q_d   = MAX_Q;
          err_d = 1'b1;
        end else begin
          q_d = shl_val;
        end
      end else if (SHR) begin
        if (shr_bad) begin
          q_d   = MAX_Q;
          err_d = 1'b1;
        end else begin
          q_d = shr_val;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      q_q   <= RST_Q;
      co_q  <= 1'b0;
      bo_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      bo_q  <= bo_d;
      err_q <= err_d;
    end
  end

  assign Q   = q_q;
  assign CO  = co_q;
  assign BO  = bo_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_counter_mod_updown_shift.sv
// Bench for counter_mod_updown_shift: three instances (8-bit mod 256, 4-bit mod 10
// step 3, 4-bit mod 10 step 1) driven from a directed vector table plus a few
// hand-written reset sequences. Expectations follow COUNTER_MOD_SATURATE_EN.
module tb_counter_mod_updown_shift;

`ifdef COUNTER_MOD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // op bits {L, INC, DEC, SHL, SHR}; sb bits {ROT, SIL, SIR}
  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] OL  = 5'b10000;
  localparam logic [4:0] OI  = 5'b01000;
  localparam logic [4:0] OD  = 5'b00100;
  localparam logic [4:0] OSL = 5'b00010;
  localparam logic [4:0] OSR = 5'b00001;

  typedef struct packed {
    logic       r, ce, l, inc, dec, shl, shr, rot, sil, sir;
    logic [7:0] d;
  } drv_t;

  typedef struct {
    string      name;
    int         id;
    bit         r;
    bit         ce;
    logic [4:0] op;
    logic [2:0] sb;
    logic [7:0] d;
    logic [7:0] q;
    logic [2:0] f;   // {CO, BO, ERR}
  } vec_t;

  logic C;
  drv_t drv0, drv1, drv2;
  logic [7:0] q0;
  logic [3:0] q1, q2;
  logic co0, bo0, er0, co1, bo1, er1, co2, bo2, er2;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs[$];

  counter_mod_updown_shift #(.WIDTH(8), .MODULUS(256), .STEP(1), .RESET_VAL(8'h5A)) u8 (
    .C(C), .R(drv0.r), .CE(drv0.ce), .D(drv0.d), .L(drv0.l), .INC(drv0.inc), .DEC(drv0.dec),
    .SHL(drv0.shl), .SHR(drv0.shr), .ROT(drv0.rot), .SIL(drv0.sil), .SIR(drv0.sir),
    .Q(q0), .CO(co0), .BO(bo0), .ERR(er0));

  counter_mod_updown_shift #(.WIDTH(4), .MODULUS(10), .STEP(3), .RESET_VAL(0)) u4 (
    .C(C), .R(drv1.r), .CE(drv1.ce), .D(drv1.d[3:0]), .L(drv1.l), .INC(drv1.inc), .DEC(drv1.dec),
    .SHL(drv1.shl), .SHR(drv1.shr), .ROT(drv1.rot), .SIL(drv1.sil), .SIR(drv1.sir),
    .Q(q1), .CO(co1), .BO(bo1), .ERR(er1));

  counter_mod_updown_shift #(.WIDTH(4), .MODULUS(10), .STEP(1), .RESET_VAL(0)) u4s (
    .C(C), .R(drv2.r), .CE(drv2.ce), .D(drv2.d[3:0]), .L(drv2.l), .INC(drv2.inc), .DEC(drv2.dec),
    .SHL(drv2.shl), .SHR(drv2.shr), .ROT(drv2.rot), .SIL(drv2.sil), .SIR(drv2.sir),
    .Q(q2), .CO(co2), .BO(bo2), .ERR(er2));

  initial C = 1'b0;
  always #5 C = ~C;

  function automatic vec_t mk(string name, int id, bit r, bit ce, logic [4:0] op,
                              logic [2:0] sb, logic [7:0] d, logic [7:0] q, logic [2:0] f);
    vec_t v;
    v.name = name; v.id = id; v.r = r; v.ce = ce; v.op = op;
    v.sb = sb; v.d = d; v.q = q; v.f = f;
    return v;
  endfunction

  function automatic logic [7:0] rd_q(int id);
    case (id)
      0:       return q0;
      1:       return {4'h0, q1};
      default: return {4'h0, q2};
    endcase
  endfunction

  function automatic logic [2:0] rd_f(int id);
    case (id)
      0:       return {co0, bo0, er0};
      1:       return {co1, bo1, er1};
      default: return {co2, bo2, er2};
    endcase
  endfunction

  task automatic set_drv(int id, drv_t t);
    case (id)
      0:       drv0 = t;
      1:       drv1 = t;
      default: drv2 = t;
    endcase
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic run_vec(vec_t v);
    drv_t t;
    t.r = v.r;
    t.ce = v.ce;
    {t.l, t.inc, t.dec, t.shl, t.shr} = v.op;
    {t.rot, t.sil, t.sir} = v.sb;
    t.d = v.d;
    set_drv(v.id, t);
    @(posedge C);
    #1;
    chk({v.name, ".q"}, rd_q(v.id), v.q);
    chk({v.name, ".co_bo_err"}, {5'b0, rd_f(v.id)}, {5'b0, v.f});
    set_drv(v.id, '0);
  endtask

  initial begin
    // 8-bit mod 256: load, shift and rotate
    vecs.push_back(mk("u8_load3c",     0, 0, 1, OL,        3'b000, 8'h3C, 8'h3C, 3'b000));
    vecs.push_back(mk("u8_load81a",    0, 0, 1, OL,        3'b000, 8'h81, 8'h81, 3'b000));
    vecs.push_back(mk("u8_shl_rot",    0, 0, 1, OSL,       3'b100, 8'h00, 8'h03, 3'b000));
    vecs.push_back(mk("u8_load81b",    0, 0, 1, OL,        3'b000, 8'h81, 8'h81, 3'b000));
    vecs.push_back(mk("u8_shr_sir0",   0, 0, 1, OSR,       3'b000, 8'h00, 8'h40, 3'b000));
    vecs.push_back(mk("u8_load81c",    0, 0, 1, OL,        3'b000, 8'h81, 8'h81, 3'b000));
    vecs.push_back(mk("u8_shl_sil1",   0, 0, 1, OSL,       3'b010, 8'h00, 8'h03, 3'b000));
    vecs.push_back(mk("u8_shl_wins",   0, 0, 1, OSL | OSR, 3'b001, 8'h00, 8'h06, 3'b000));
    vecs.push_back(mk("u8_shr_sir1",   0, 0, 1, OSR,       3'b001, 8'h00, 8'h83, 3'b000));
    vecs.push_back(mk("u8_shr_rot",    0, 0, 1, OSR,       3'b100, 8'h00, 8'hC1, 3'b000));
    vecs.push_back(mk("u8_loadff",     0, 0, 1, OL,        3'b000, 8'hFF, 8'hFF, 3'b000));
    vecs.push_back(mk("u8_inc_top",    0, 0, 1, OI,        3'b000, 8'h00, SAT ? 8'hFF : 8'h00, 3'b100));
    vecs.push_back(mk("u8_co_clear",   0, 0, 1, NOP,       3'b000, 8'h00, SAT ? 8'hFF : 8'h00, 3'b000));
    vecs.push_back(mk("u8_dec",        0, 0, 1, OD,        3'b000, 8'h00, SAT ? 8'hFE : 8'hFF,
                      SAT ? 3'b000 : 3'b010));
    // 4-bit mod 10 step 3: wrap / saturate, shift error
    vecs.push_back(mk("u4_load8",      1, 0, 1, OL,  3'b000, 8'd8, 8'd8, 3'b000));
    vecs.push_back(mk("u4_inc_over",   1, 0, 1, OI,  3'b000, 8'd0, SAT ? 8'd9 : 8'd1, 3'b100));
    vecs.push_back(mk("u4_co_clear",   1, 0, 1, NOP, 3'b000, 8'd0, SAT ? 8'd9 : 8'd1, 3'b000));
    vecs.push_back(mk("u4_load1",      1, 0, 1, OL,  3'b000, 8'd1, 8'd1, 3'b000));
    vecs.push_back(mk("u4_dec_under",  1, 0, 1, OD,  3'b000, 8'd0, SAT ? 8'd0 : 8'd8, 3'b010));
    vecs.push_back(mk("u4_bo_clear",   1, 0, 1, NOP, 3'b000, 8'd0, SAT ? 8'd0 : 8'd8, 3'b000));
    vecs.push_back(mk("u4_load5",      1, 0, 1, OL,  3'b000, 8'd5, 8'd5, 3'b000));
    vecs.push_back(mk("u4_inc_5to8",   1, 0, 1, OI,  3'b000, 8'd0, 8'd8, 3'b000));
    vecs.push_back(mk("u4_inc_8",      1, 0, 1, OI,  3'b000, 8'd0, SAT ? 8'd9 : 8'd1, 3'b100));
    vecs.push_back(mk("u4_inc_again",  1, 0, 1, OI,  3'b000, 8'd0, SAT ? 8'd9 : 8'd4,
                      SAT ? 3'b100 : 3'b000));
    vecs.push_back(mk("u4_load2",      1, 0, 1, OL,  3'b000, 8'd2, 8'd2, 3'b000));
    vecs.push_back(mk("u4_dec_2",      1, 0, 1, OD,  3'b000, 8'd0, SAT ? 8'd0 : 8'd9, 3'b010));
    vecs.push_back(mk("u4_load9",      1, 0, 1, OL,  3'b000, 8'd9, 8'd9, 3'b000));
    vecs.push_back(mk("u4_dec_9",      1, 0, 1, OD,  3'b000, 8'd0, 8'd6, 3'b000));
    vecs.push_back(mk("u4_load5b",     1, 0, 1, OL,  3'b000, 8'd5, 8'd5, 3'b000));
    vecs.push_back(mk("u4_shl_err",    1, 0, 1, OSL, 3'b010, 8'd0, 8'd9, 3'b001));
    vecs.push_back(mk("u4_err_sticky", 1, 0, 1, OL,  3'b000, 8'd3, 8'd3, 3'b001));
    // 4-bit mod 10 step 1: protocol errors, priority, reset, enable
    vecs.push_back(mk("u4s_load4",     2, 0, 1, OL,      3'b000, 8'd4,  8'd4, 3'b000));
    vecs.push_back(mk("u4s_incdec",    2, 0, 1, OI | OD, 3'b000, 8'd0,  8'd5, 3'b001));
    vecs.push_back(mk("u4s_err_hold",  2, 0, 1, NOP,     3'b000, 8'd0,  8'd5, 3'b001));
    vecs.push_back(mk("u4s_load_wins", 2, 0, 1, OL | OI, 3'b000, 8'd7,  8'd7, 3'b001));
    vecs.push_back(mk("u4s_rst_held",  2, 1, 1, OL,      3'b000, 8'd6,  8'd0, 3'b000));
    vecs.push_back(mk("u4s_load12",    2, 0, 1, OL,      3'b000, 8'd12, 8'd9, 3'b001));
    vecs.push_back(mk("u4s_rst2",      2, 1, 1, NOP,     3'b000, 8'd0,  8'd0, 3'b000));
    vecs.push_back(mk("u4s_load5",     2, 0, 1, OL,      3'b000, 8'd5,  8'd5, 3'b000));
    vecs.push_back(mk("u4s_shr_err",   2, 0, 1, OSR,     3'b100, 8'd0,  8'd9, 3'b001));
    vecs.push_back(mk("u4s_rst3",      2, 1, 1, NOP,     3'b000, 8'd0,  8'd0, 3'b000));
    vecs.push_back(mk("u4s_dec_0",     2, 0, 1, OD,      3'b000, 8'd0,  SAT ? 8'd0 : 8'd9, 3'b010));
    vecs.push_back(mk("u4s_inc_back",  2, 0, 1, OI,      3'b000, 8'd0,  SAT ? 8'd1 : 8'd0,
                      SAT ? 3'b000 : 3'b100));
    vecs.push_back(mk("u4s_load4b",    2, 0, 1, OL,      3'b000, 8'd4,  8'd4, 3'b000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk($sformatf("u4s_ce0_inc%0d", i), 2, 0, 0, OI, 3'b000, 8'd0, 8'd4, 3'b000));
    vecs.push_back(mk("u4s_ce0_incdec", 2, 0, 0, OI | OD, 3'b000, 8'd0,  8'd4, 3'b000));
    vecs.push_back(mk("u4s_ce0_load12", 2, 0, 0, OL,      3'b000, 8'd12, 8'd4, 3'b000));
    vecs.push_back(mk("u4s_ce1_inc",    2, 0, 1, OI,      3'b000, 8'd0,  8'd5, 3'b000));
    vecs.push_back(mk("u4s_load9",      2, 0, 1, OL,      3'b000, 8'd9,  8'd9, 3'b000));
    vecs.push_back(mk("u4s_inc_9",      2, 0, 1, OI,      3'b000, 8'd0,  SAT ? 8'd9 : 8'd0, 3'b100));
    vecs.push_back(mk("u4s_ce0_coclr",  2, 0, 0, OI,      3'b000, 8'd0,  SAT ? 8'd9 : 8'd0, 3'b000));

    // Reset asserted from time zero: values appear before any clock edge.
    drv0 = '0; drv1 = '0; drv2 = '0;
    drv0.r = 1'b1; drv1.r = 1'b1; drv2.r = 1'b1;
    #2;
    chk("rst_async_q8", q0, 8'h5A);
    chk("rst_async_f8", {5'b0, co0, bo0, er0}, 8'h00);
    chk("rst_async_q4", {4'h0, q1}, 8'h00);
    chk("rst_async_q4s", {4'h0, q2}, 8'h00);
    @(posedge C);
    #1;
    drv0 = '0; drv1 = '0; drv2 = '0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-cycle on top of a pending load: aborts the load, no clock needed.
    drv0 = '0;
    drv0.ce = 1'b1; drv0.l = 1'b1; drv0.d = 8'h22; drv0.r = 1'b1;
    #2;
    chk("u8_midrst_async", q0, 8'h5A);
    @(posedge C);
    #1;
    chk("u8_midrst_abort", q0, 8'h5A);
    drv0 = '0;
    drv0.ce = 1'b1; drv0.inc = 1'b1;
    @(posedge C);
    #1;
    chk("u8_after_release", q0, 8'h5B);
    drv0 = '0;

    // Sticky ERR on u4 is cleared by R alone, asynchronously.
    drv1 = '0;
    drv1.r = 1'b1; drv1.ce = 1'b1; drv1.inc = 1'b1;
    #2;
    chk("u4_err_rst", {7'b0, er1}, 8'h00);
    chk("u4_q_rst", {4'h0, q1}, 8'h00);
    @(posedge C);
    #1;
    drv1 = '0;
    drv1.ce = 1'b1; drv1.inc = 1'b1;
    @(posedge C);
    #1;
    chk("u4_inc_after_rst", {4'h0, q1}, 8'h03);
    chk("u4_flags_after_rst", {5'b0, co1, bo1, er1}, 8'h00);
    drv1 = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_mod_updown_shift.md
Name: counter_mod_updown_shift

Overview:
- Parametrised successor of the team's 4-bit load/inc/dec/shift counter.
- Generalised to WIDTH bits, an arbitrary modulus and a programmable step.
- Adds count enable, asynchronous reset, selectable rotate, carry/borrow pulses and a sticky error flag.
- Used as a general-purpose sequencer/address counter in datapath exercises; one instance per counter, single clock domain.

Parameters:
- WIDTH, 8: register width in bits, 2..32.
- MODULUS, 256: count range 0..MODULUS-1. Constraint: 2 <= MODULUS <= 2^WIDTH.
- STEP, 1: increment/decrement amount. Constraint: 1 <= STEP < MODULUS.
- RESET_VAL, 0: value of Q after reset. Constraint: < MODULUS.

Ports:
- C  input  1  clock, rising edge active
- R  input  1  reset, asynchronous, active-high
- CE  input  1  clock enable; when 0, Q holds and CO/BO are 0
- D  input  WIDTH  parallel load data
- L  input  1  load
- INC  input  1  increment by STEP
- DEC  input  1  decrement by STEP
- SHL  input  1  shift left
- SHR  input  1  shift right
- ROT  input  1  1 = shifts rotate, 0 = shifts take serial inputs
- SIL  input  1  serial in for SHL (enters at bit 0)
- SIR  input  1  serial in for SHR (enters at bit WIDTH-1)
- Q  output  WIDTH  counter value, registered
- CO  output  1  carry pulse, registered
- BO  output  1  borrow pulse, registered
- ERR  output  1  sticky error flag, registered

Behaviour:
- Reset: R=1 forces Q=RESET_VAL, CO=0, BO=0, ERR=0 immediately, with no clock needed. Release is synchronous to the next rising edge of C. R asserted mid-operation aborts that operation; there is no partial update.
- All updates occur on the rising edge of C with CE=1. Latency is 1 cycle.
- Invariant: Q < MODULUS at all times.
- Operation priority: L > INC > DEC > SHL > SHR > hold. Exactly one operation executes per cycle.
- Load:
  - D < MODULUS: Q <= D.
  - D >= MODULUS: Q <= MODULUS-1 and ERR <= 1.
- Increment:
  - Q+STEP < MODULUS: Q <= Q+STEP.
  - Otherwise: Q <= Q+STEP-MODULUS (wrap) and CO=1 for exactly that cycle.
  - Compute in WIDTH+1 bits so there is no intermediate overflow.
- Decrement:
  - Q >= STEP: Q <= Q-STEP.
  - Otherwise: Q <= Q+MODULUS-STEP and BO=1 for that cycle.
- Shift left: result = {Q[WIDTH-2:0], ROT ? Q[WIDTH-1] : SIL}.
- Shift right: result = {ROT ? Q[0] : SIR, Q[WIDTH-1:1]}.
- Shift result >= MODULUS (only possible when MODULUS < 2^WIDTH): Q <= MODULUS-1 and ERR <= 1.
- INC and DEC both high with L=0: INC executes and ERR <= 1 (protocol violation).
- SHL and SHR both high: SHL executes. This is not an error.
- CO and BO are cleared on every clock edge on which they are not re-asserted. They are never both 1.
- ERR is cleared only by R.
- CE=0: Q and ERR hold, CO=BO=0. Requests seen while CE=0 are not logged in ERR.

Optional Feature:
- Macro: COUNTER_MOD_SATURATE_EN.
- Defined: increment and decrement saturate instead of wrapping.
  - An increment that would pass MODULUS-1 sets Q to MODULUS-1 and pulses CO.
  - A decrement that would go below 0 sets Q to 0 and pulses BO.
  - A pulse also occurs when Q is already at the limit.
- Not defined: wrap-around as described in Behaviour.
- Load, shift and error behaviour are identical in both builds.

Test Plan:
- Reset and load (WIDTH=8, MODULUS=256, RESET_VAL=0x5A): assert R between edges -> Q=0x5A before the next edge. Release R, L=1, D=0x3C -> Q=0x3C after 1 cycle, ERR=0.
- Modulo wrap (WIDTH=4, MODULUS=10, STEP=3):
  - From Q=8, INC -> Q=1, CO=1 for one cycle.
  - From Q=1, DEC -> Q=8, BO=1 for one cycle.
  - From Q=5, INC -> Q=8, CO=0.
- Shift/rotate (WIDTH=8, MODULUS=256), Q=0x81:
  - SHL, ROT=1 -> 0x03.
  - SHR, ROT=0, SIR=0 -> 0x40.
  - SHL, ROT=0, SIL=1 -> 0x03.
- Errors and priority (WIDTH=4, MODULUS=10):
  - L=1, D=12 -> Q=9, ERR=1.
  - After reset, Q=4, INC=DEC=1 -> Q=5, ERR=1, held until R.
  - L=1 with INC=1 -> load wins.
- Enable: CE=0 while INC pulses for 5 cycles -> Q unchanged, CO=0. CE=1 -> counting resumes on the next edge.
- Saturate build (COUNTER_MOD_SATURATE_EN, MODULUS=10, STEP=3):
  - From Q=8, INC -> Q=9, CO=1; INC again -> Q=9, CO=1.
  - From Q=2, DEC -> Q=0, BO=1.
